// File: rtl/xor_frame_checker_if.sv
// Stream-side bundle for xor_frame_checker: word input channel and result channel.
// The slave modport is the checker's view; the master modport is the source/sink side.
interface xor_frame_checker_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_err;
    logic             out_ovf;
    logic [CNT_W-1:0] out_len;

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_ovf, out_len
    );

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_ovf, out_len
    );
endinterface

// File: rtl/xor_frame_checker.sv
// XOR checksum generator/checker for in_last-framed word streams.
// Frames longer than MAX_LEN are drained to their in_last and flagged as overflow.
module xor_frame_checker #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xor_frame_checker_if.slave   bus,
    output logic [7:0]           frame_cnt
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] len, len_n;
    logic             ovf, ovf_n;
    logic             mode_q, mode_n;
    logic             in_ready_n;
    logic             out_valid_n, out_err_n, out_ovf_n;
    logic [WIDTH-1:0] out_sum_n;
    logic [CNT_W-1:0] out_len_n;
    logic [7:0]       frame_cnt_n;
    logic             accept, finish;

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            len           <= '0;
            ovf           <= 1'b0;
            mode_q        <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_err   <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_len   <= '0;
            frame_cnt     <= '0;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            len           <= len_n;
            ovf           <= ovf_n;
            mode_q        <= mode_n;
            bus.in_ready  <= in_ready_n;
            bus.out_valid <= out_valid_n;
            bus.out_sum   <= out_sum_n;
            bus.out_err   <= out_err_n;
            bus.out_ovf   <= out_ovf_n;
            bus.out_len   <= out_len_n;
            frame_cnt     <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        len_n       = len;
        ovf_n       = ovf;
        mode_n      = mode_q;
        out_valid_n = bus.out_valid;
        out_sum_n   = bus.out_sum;
        out_err_n   = bus.out_err;
        out_ovf_n   = bus.out_ovf;
        out_len_n   = bus.out_len;
        frame_cnt_n = frame_cnt;
        finish      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    acc_n  = bus.in_data;
                    len_n  = CNT_W'(1);
                    ovf_n  = 1'b0;
                    mode_n = bus.mode;
                    if (bus.in_last) finish = 1'b1;
                    else             state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_n = acc ^ bus.in_data;
                    len_n = len + CNT_W'(1);
                    if (bus.in_last) begin
                        finish = 1'b1;
                    end else if (len_n == CNT_W'(MAX_LEN)) begin
                        state_n = DRAIN;
                        ovf_n   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.in_last) finish = 1'b1;
            end
            DONE: begin
                if (bus.out_valid && bus.out_ready) begin
                    out_valid_n = 1'b0;
                    frame_cnt_n = frame_cnt + 8'd1;
                    ovf_n       = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Result fields are taken from the post-update accumulator so the last word is included.
        if (finish) begin
            state_n     = DONE;
            out_valid_n = 1'b1;
            out_sum_n   = acc_n;
            out_len_n   = len_n;
            out_ovf_n   = ovf_n;
            out_err_n   = ovf_n | (mode_n & (|acc_n));
        end

        in_ready_n = (state_n != DONE);
    end
endmodule
